// File: rtl/axi_seq_pkg.sv
// rtl/axi_seq_pkg.sv - shared state encoding and default timing constants for the sequencer
package axi_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_GAP,
      ST_FINISH
   } seq_state_e;

   localparam int DEF_RUNS_W         = 16;
   localparam int DEF_GAP_CYCLES     = 16;
   localparam int DEF_TIMEOUT_CYCLES = 4096;

   // The shared timer only ever holds GAP_CYCLES-1 or TIMEOUT_CYCLES-1.
   function automatic int timer_width(input int gap_cycles, input int timeout_cycles);
      int m;
      m = (gap_cycles > timeout_cycles) ? gap_cycles : timeout_cycles;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable down-counter with zero flag, shared by gap and timeout timing
module seq_timer #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Holds at zero once reached so a lingering decrement cannot wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/axi_txn_sequencer.sv
// rtl/axi_txn_sequencer.sv - launches AXI master test runs, waits for completion, gaps, tallies results
module axi_txn_sequencer
   import axi_seq_pkg::*;
#(
   parameter int RUNS_W         = DEF_RUNS_W,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [RUNS_W-1:0] num_runs,
   input  logic              abort,
   input  logic              txn_done,
   input  logic              txn_error,
   output logic              init_txn,
   output logic              busy,
   output logic              done,
   output logic [RUNS_W-1:0] run_cnt,
   output logic [RUNS_W-1:0] err_cnt,
   output logic              timeout
);

   localparam int TMR_W = timer_width(GAP_CYCLES, TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   seq_state_e        state_q, state_d;
   logic [RUNS_W-1:0] num_runs_q, num_runs_d;
   logic [RUNS_W-1:0] run_cnt_q, run_cnt_d;
   logic [RUNS_W-1:0] err_cnt_q, err_cnt_d;
   logic              timeout_q, timeout_d;
   logic              err_flag_q, err_flag_d;
   logic [RUNS_W-1:0] run_inc;

   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_dec;
   logic              tmr_zero;

   function automatic logic [RUNS_W-1:0] sat_inc(input logic [RUNS_W-1:0] v);
      return (&v) ? v : v + RUNS_W'(1);
   endfunction

   seq_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d    = state_q;
      num_runs_d = num_runs_q;
      run_cnt_d  = run_cnt_q;
      err_cnt_d  = err_cnt_q;
      timeout_d  = timeout_q;
      err_flag_d = err_flag_q;
      tmr_load   = 1'b0;
      tmr_val    = TMO_LOAD;
      tmr_dec    = 1'b0;
      run_inc    = sat_inc(run_cnt_q);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_runs_d = num_runs;
               run_cnt_d  = '0;
               err_cnt_d  = '0;
               timeout_d  = 1'b0;
               state_d    = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            err_flag_d = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = TMO_LOAD;
            state_d    = abort ? ST_FINISH : ST_WAIT;
         end
         ST_WAIT: begin
            tmr_dec = 1'b1;
            if (txn_error) begin
               err_flag_d = 1'b1;
            end
            // Abort discards the in-flight run, even if it completes this very cycle.
            if (abort) begin
               state_d = ST_FINISH;
            end else if (txn_done) begin
               run_cnt_d = run_inc;
               if (err_flag_q || txn_error) begin
                  err_cnt_d = sat_inc(err_cnt_q);
               end
               if ((num_runs_q != '0) && (run_inc == num_runs_q)) begin
                  state_d = ST_FINISH;
               end else if (GAP_CYCLES == 0) begin
                  state_d = ST_LAUNCH;
               end else begin
                  tmr_load = 1'b1;
                  tmr_val  = GAP_LOAD;
                  state_d  = ST_GAP;
               end
            end else if (tmr_zero) begin
               timeout_d = 1'b1;
               err_cnt_d = sat_inc(err_cnt_q);
               state_d   = ST_FINISH;
            end
         end
         ST_GAP: begin
            tmr_dec = 1'b1;
            if (abort) begin
               state_d = ST_FINISH;
            end else if (tmr_zero) begin
               state_d = ST_LAUNCH;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         num_runs_q <= '0;
         run_cnt_q  <= '0;
         err_cnt_q  <= '0;
         timeout_q  <= 1'b0;
         err_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_runs_q <= num_runs_d;
         run_cnt_q  <= run_cnt_d;
         err_cnt_q  <= err_cnt_d;
         timeout_q  <= timeout_d;
         err_flag_q <= err_flag_d;
      end
   end

   assign init_txn = (state_q == ST_LAUNCH);
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_FINISH);
   assign run_cnt  = run_cnt_q;
   assign err_cnt  = err_cnt_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// tb/tb_axi_txn_sequencer.sv - directed vector bench for axi_txn_sequencer
module tb_axi_txn_sequencer;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;
   int   checks = 0;
   int   errors = 0;

   logic        a_start = 1'b0, a_abort = 1'b0, a_done_in = 1'b0, a_err_in = 1'b0;
   logic [15:0] a_num = '0;
   logic        a_init, a_busy, a_done, a_to;
   logic [15:0] a_run, a_err;

   logic        b_start = 1'b0, b_abort = 1'b0, b_done_in = 1'b0, b_err_in = 1'b0;
   logic [3:0]  b_num = '0;
   logic        b_init, b_busy, b_done, b_to;
   logic [3:0]  b_run, b_err;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axi_txn_sequencer #(.RUNS_W(16), .GAP_CYCLES(16), .TIMEOUT_CYCLES(64)) u_dut_a (
      .clk(clk), .rstn(rstn), .start(a_start), .num_runs(a_num), .abort(a_abort),
      .txn_done(a_done_in), .txn_error(a_err_in), .init_txn(a_init), .busy(a_busy),
      .done(a_done), .run_cnt(a_run), .err_cnt(a_err), .timeout(a_to)
   );

   axi_txn_sequencer #(.RUNS_W(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(4096)) u_dut_b (
      .clk(clk), .rstn(rstn), .start(b_start), .num_runs(b_num), .abort(b_abort),
      .txn_done(b_done_in), .txn_error(b_err_in), .init_txn(b_init), .busy(b_busy),
      .done(b_done), .run_cnt(b_run), .err_cnt(b_err), .timeout(b_to)
   );

   typedef struct {
      int n; int dly; int er; int ep; int bs;
      int x_launch; int x_run; int x_err; int x_to; int x_lat;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Master model: txn_done dly cycles after each init_txn (0 = never), optional error pulse.
   task automatic run_vec(input vec_t v, input int idx);
      int  t0, pend, launches, last_launch, sp_bad, lat;
      bit  seen;
      a_num = 16'(v.n);
      a_start = 1'b1;
      t0 = cyc;
      step();
      a_start = 1'b0;
      chk($sformatf("v%0d init at s+1", idx), int'(a_init), 1);
      chk($sformatf("v%0d busy at s+1", idx), int'(a_busy), 1);
      pend = 0; launches = 0; last_launch = -1; sp_bad = 0; lat = -1; seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         a_done_in = 1'b0;
         a_err_in  = 1'b0;
         a_start   = 1'b0;
         if (a_done) begin
            seen = 1'b1;
            lat  = cyc - t0;
         end else if (a_init) begin
            launches++;
            if (last_launch >= 0 && (cyc - last_launch) != v.dly + 17) sp_bad++;
            last_launch = cyc;
            pend = v.dly;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) a_done_in = 1'b1;
            if (launches == v.er && pend == v.ep) a_err_in = 1'b1;
            if (v.bs != 0) begin
               a_start = 1'b1;
               a_num   = 16'd7;
            end
         end
         if (!seen) step();
      end
      a_done_in = 1'b0; a_err_in = 1'b0; a_start = 1'b0;
      chk($sformatf("v%0d done seen", idx), int'(seen), 1);
      chk($sformatf("v%0d done latency", idx), lat, v.x_lat);
      chk($sformatf("v%0d launches", idx), launches, v.x_launch);
      chk($sformatf("v%0d launch spacing errs", idx), sp_bad, 0);
      chk($sformatf("v%0d run_cnt", idx), int'(a_run), v.x_run);
      chk($sformatf("v%0d err_cnt", idx), int'(a_err), v.x_err);
      chk($sformatf("v%0d timeout", idx), int'(a_to), v.x_to);
      step();
      chk($sformatf("v%0d done one cycle", idx), int'(a_done), 0);
      chk($sformatf("v%0d busy low after", idx), int'(a_busy), 0);
      chk($sformatf("v%0d timeout sticky", idx), int'(a_to), v.x_to);
   endtask

   initial begin
      int  pend, comp, ac, last_done, gap_bad, rec15;
      bit  fin;

      vecs[0] = '{3, 10, 0, 0, 0, 3, 3, 0, 0, 66};
      vecs[1] = '{4, 10, 2, 5, 0, 4, 4, 1, 0, 93};
      vecs[2] = '{2,  0, 0, 0, 0, 1, 0, 1, 1, 66};
      vecs[3] = '{1,  1, 0, 0, 0, 1, 1, 0, 0,  3};
      vecs[4] = '{2,  6, 2, 0, 0, 2, 2, 1, 0, 31};
      vecs[5] = '{1, 64, 0, 0, 0, 1, 1, 0, 0, 66};
      vecs[6] = '{1, 65, 0, 0, 0, 1, 0, 1, 1, 66};
      vecs[7] = '{2, 10, 0, 0, 1, 2, 2, 0, 0, 39};

      #1;
      chk("reset init_txn", int'(a_init), 0);
      chk("reset busy", int'(a_busy), 0);
      chk("reset done", int'(a_done), 0);
      chk("reset timeout", int'(a_to), 0);
      chk("reset run_cnt", int'(a_run), 0);
      chk("reset err_cnt", int'(a_err), 0);
      step(); step();
      rstn = 1'b1;
      step();

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i + 1);

      // Continuous mode; abort lands on the same cycle as the sixth completion.
      a_num = '0; a_start = 1'b1; step(); a_start = 1'b0;
      pend = 0; comp = 0; ac = -1; fin = 1'b0;
      for (int k = 0; k < 600 && !fin; k++) begin
         a_done_in = 1'b0; a_abort = 1'b0;
         if (a_done) fin = 1'b1;
         else if (a_init) pend = 10;
         else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               a_done_in = 1'b1;
               comp++;
               if (comp == 6) begin a_abort = 1'b1; ac = cyc; end
            end
         end
         if (!fin) step();
      end
      a_done_in = 1'b0; a_abort = 1'b0;
      chk("abort done seen", int'(fin), 1);
      chk("abort done next cycle", cyc, ac + 1);
      chk("abort run_cnt", int'(a_run), 5);
      chk("abort err_cnt", int'(a_err), 0);
      step();
      chk("abort busy low", int'(a_busy), 0);

      // Idle-state noise must do nothing.
      a_abort = 1'b1; a_done_in = 1'b1; a_err_in = 1'b1;
      step(); step(); step();
      chk("idle noise busy", int'(a_busy), 0);
      chk("idle noise done", int'(a_done), 0);
      chk("idle noise run_cnt", int'(a_run), 5);
      chk("idle noise err_cnt", int'(a_err), 0);
      a_abort = 1'b0; a_done_in = 1'b0; a_err_in = 1'b0;

      // Reset during WAIT of the second run.
      a_num = 16'd3; a_start = 1'b1; step(); a_start = 1'b0;
      for (int k = 0; k < 9; k++) step();
      a_done_in = 1'b1; step(); a_done_in = 1'b0;
      for (int k = 0; k < 40 && !a_init; k++) step();
      chk("pre-reset second launch", int'(a_init), 1);
      step(); step();
      chk("pre-reset run_cnt", int'(a_run), 1);
      chk("pre-reset busy", int'(a_busy), 1);
      rstn = 1'b0;
      #1;
      chk("async reset busy", int'(a_busy), 0);
      chk("async reset run_cnt", int'(a_run), 0);
      chk("async reset init", int'(a_init), 0);
      step();
      rstn = 1'b1;
      fin = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (a_done || a_busy) fin = 1'b1;
         step();
      end
      chk("no done after reset", int'(fin), 0);

      // Zero-gap continuous mode on the 4-bit instance, through saturation.
      b_num = '0; b_start = 1'b1; step(); b_start = 1'b0;
      pend = 0; comp = 0; last_done = -10; gap_bad = 0; rec15 = -1;
      for (int k = 0; k < 300; k++) begin
         b_done_in = 1'b0;
         if (b_init) begin
            if (comp > 0 && cyc != last_done + 1) gap_bad++;
            pend = 2;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               b_done_in = 1'b1;
               comp++;
               last_done = cyc;
               if (comp == 16) rec15 = int'(b_run);
            end
         end
         step();
         if (comp == 20) break;
      end
      b_done_in = 1'b0;
      chk("gap0 completions", comp, 20);
      chk("gap0 relaunch spacing errs", gap_bad, 0);
      chk("gap0 run_cnt at 15", rec15, 15);
      chk("gap0 run_cnt saturated", int'(b_run), 15);
      chk("gap0 launch after sat", int'(b_init), 1);

      // Abort in LAUNCH with start held high: one IDLE cycle, then relaunch.
      b_abort = 1'b1; b_start = 1'b1;
      step();
      b_abort = 1'b0;
      chk("launch abort done", int'(b_done), 1);
      chk("launch abort run_cnt", int'(b_run), 15);
      step();
      chk("held start idle busy", int'(b_busy), 0);
      step();
      chk("held start relaunch", int'(b_init), 1);
      chk("relaunch run_cnt cleared", int'(b_run), 0);
      b_start = 1'b0; b_abort = 1'b1;
      step();
      b_abort = 1'b0;
      step();
      chk("final idle", int'(b_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
